// File: rtl/dffr_reset_seq.sv
// Reset sequencer for the async-clear register domains of the CPU core.
// After a block reset or a global re-clear request all domains are held
// cleared and then released one by one in ascending index order. While
// running, a single domain can be re-cleared on request. Every output is
// a flop, so the async-clear pins fed by nreset_o never see glitches.
module dffr_reset_seq #(
    parameter int N_DOMAINS     = 4,
    parameter int ASSERT_CYCLES = 8,
    parameter int GAP_CYCLES    = 4,
    parameter int CNT_W         = 8,
    localparam int IDX_W        = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rst_req,
    input  logic                 dom_req,
    input  logic [IDX_W-1:0]     dom_sel,
    output logic [N_DOMAINS-1:0] nreset_o,
    output logic                 ready,
    output logic                 busy,
    output logic                 dom_done
);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN,
        ST_DOM
    } state_t;

    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DOMAINS - 1);
    // One extra bit so that N_DOMAINS itself is representable for the
    // out-of-range check on dom_sel.
    localparam logic [IDX_W:0]   N_DOM_EXT   = (IDX_W + 1)'(N_DOMAINS);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [IDX_W-1:0]     sel_reg, sel_next;
    logic [N_DOMAINS-1:0] nreset_reg, nreset_next;
    logic                 ready_reg, ready_next;
    logic                 busy_reg, busy_next;
    logic                 dom_done_reg, dom_done_next;

    // One-hot decodes of the domain indices. Built per bit so that an index
    // value beyond the last domain simply selects nothing.
    logic [N_DOMAINS-1:0] idx_mask;
    logic [N_DOMAINS-1:0] sel_mask;
    logic [N_DOMAINS-1:0] req_mask;
    logic                 dom_sel_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N_DOMAINS; gi++) begin : g_mask
            assign idx_mask[gi] = (idx_reg == IDX_W'(gi));
            assign sel_mask[gi] = (sel_reg == IDX_W'(gi));
            assign req_mask[gi] = (dom_sel == IDX_W'(gi));
        end
    endgenerate

    assign dom_sel_ok = ({1'b0, dom_sel} < N_DOM_EXT);

    // State, counters and registered outputs; reset forces the clear phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_ASSERT;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            sel_reg      <= '0;
            nreset_reg   <= '0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            dom_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            sel_reg      <= sel_next;
            nreset_reg   <= nreset_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            dom_done_reg <= dom_done_next;
        end
    end

    // Next-state and next-output logic; a global request wins everywhere.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        sel_next      = sel_reg;
        nreset_next   = nreset_reg;
        ready_next    = ready_reg;
        busy_next     = busy_reg;
        dom_done_next = 1'b0;

        case (state_reg)
            ST_ASSERT: begin
                nreset_next = '0;
                ready_next  = 1'b0;
                busy_next   = 1'b1;
                if (rst_req) begin
                    cnt_next = '0;
                end else if (cnt_reg == ASSERT_LAST) begin
                    nreset_next[0] = 1'b1;
                    cnt_next       = '0;
                    idx_next       = IDX_W'(1);
                    if (N_DOMAINS == 1) begin
                        state_next = ST_RUN;
                        ready_next = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (rst_req) begin
                    state_next  = ST_ASSERT;
                    nreset_next = '0;
                    ready_next  = 1'b0;
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                end else if (cnt_reg == GAP_LAST) begin
                    nreset_next = nreset_reg | idx_mask;
                    cnt_next    = '0;
                    if (idx_reg == IDX_LAST) begin
                        state_next = ST_RUN;
                        ready_next = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_RUN: begin
                if (rst_req) begin
                    state_next  = ST_ASSERT;
                    nreset_next = '0;
                    ready_next  = 1'b0;
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                end else if (dom_req && dom_sel_ok) begin
                    state_next  = ST_DOM;
                    sel_next    = dom_sel;
                    nreset_next = nreset_reg & ~req_mask;
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                end
            end

            ST_DOM: begin
                if (rst_req) begin
                    state_next  = ST_ASSERT;
                    nreset_next = '0;
                    ready_next  = 1'b0;
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                end else if (cnt_reg == ASSERT_LAST) begin
                    state_next    = ST_RUN;
                    nreset_next   = nreset_reg | sel_mask;
                    dom_done_next = 1'b1;
                    busy_next     = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_ASSERT;
            end
        endcase
    end

    assign nreset_o = nreset_reg;
    assign ready    = ready_reg;
    assign busy     = busy_reg;
    assign dom_done = dom_done_reg;

endmodule

// File: tb/tb_dffr_reset_seq.sv
// Bench for dffr_reset_seq: a timeline-based reference model checked every
// cycle, directed scenarios with literal expectations, a single-domain
// instance, and a randomized run.
module tb_dffr_reset_seq;

    localparam int N = 4;
    localparam int A = 8;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0, rst_req = 1'b0, dom_req = 1'b0;
    logic [1:0]   dom_sel = '0;
    logic [N-1:0] nreset_o;
    logic         ready, busy, dom_done;

    logic         reset1 = 1'b0, rst_req1 = 1'b0, dom_req1 = 1'b0;
    logic [0:0]   dom_sel1 = '0;
    logic [0:0]   nreset1;
    logic         ready1, busy1, dom_done1;

    int checks = 0;
    int failures = 0;

    dffr_reset_seq #(.N_DOMAINS(N), .ASSERT_CYCLES(A), .GAP_CYCLES(G), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .rst_req(rst_req), .dom_req(dom_req),
        .dom_sel(dom_sel), .nreset_o(nreset_o), .ready(ready), .busy(busy),
        .dom_done(dom_done)
    );

    dffr_reset_seq #(.N_DOMAINS(1), .ASSERT_CYCLES(1), .GAP_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset1), .rst_req(rst_req1), .dom_req(dom_req1),
        .dom_sel(dom_sel1), .nreset_o(nreset1), .ready(ready1), .busy(busy1),
        .dom_done(dom_done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: the sequence is a timeline. t counts edges since
    // the last clear; domain i is released once t >= A + i*G. A single
    // domain clear lasts exactly A edges.
    int           m_mode = 0;       // 0 sequencing, 1 running, 2 domain clear
    int           m_t = 0;
    int           m_d = 0;
    int           m_sel = 0;
    logic [N-1:0] m_n = '0;
    logic         m_ready = 1'b0, m_busy = 1'b1, m_done = 1'b0;
    bit           m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            m_done = 1'b0;
            if (reset || rst_req) begin
                if (reset) m_valid = 1'b1;
                m_mode = 0; m_t = 0; m_n = '0; m_ready = 1'b0; m_busy = 1'b1;
            end else if (m_mode == 0) begin
                m_t++;
                for (int i = 0; i < N; i++) m_n[i] = (m_t >= A + i * G);
                if (m_t == A + (N - 1) * G) begin
                    m_mode = 1; m_ready = 1'b1; m_busy = 1'b0;
                end
            end else if (m_mode == 1) begin
                if (dom_req && int'(dom_sel) < N) begin
                    m_mode = 2; m_sel = int'(dom_sel); m_d = 0;
                    m_n[m_sel] = 1'b0; m_busy = 1'b1;
                end
            end else begin
                m_d++;
                if (m_d == A) begin
                    m_n[m_sel] = 1'b1; m_done = 1'b1; m_busy = 1'b0; m_mode = 1;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset has run.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("model_nreset", 32'(nreset_o), 32'(m_n));
                chk("model_ready", 32'(ready), 32'(m_ready));
                chk("model_busy", 32'(busy), 32'(m_busy));
                chk("model_dom_done", 32'(dom_done), 32'(m_done));
            end
        end
    end

    initial begin
        // Single-domain instance, while the main instance is held in reset.
        reset = 1'b1; reset1 = 1'b1;
        cycle();
        reset1 = 1'b0;
        cycle();
        chk("n1_nreset_e1", 32'(nreset1), 32'd1);
        chk("n1_ready_e1", 32'(ready1), 32'd1);
        dom_req1 = 1'b1; dom_sel1 = 1'b1;
        cycle();
        dom_req1 = 1'b0;
        chk("n1_bad_sel_nreset", 32'(nreset1), 32'd1);
        chk("n1_bad_sel_busy", 32'(busy1), 32'd0);
        dom_req1 = 1'b1; dom_sel1 = 1'b0;
        cycle();
        dom_req1 = 1'b0;
        chk("n1_dom_nreset", 32'(nreset1), 32'd0);
        chk("n1_dom_ready", 32'(ready1), 32'd1);
        cycle();
        chk("n1_dom_release", 32'(nreset1), 32'd1);
        chk("n1_dom_done", 32'(dom_done1), 32'd1);
        cycle();
        chk("n1_dom_done_off", 32'(dom_done1), 32'd0);

        // Main instance: reset values, then the release timeline.
        chk("rst_nreset", 32'(nreset_o), 32'h0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_dom_done", 32'(dom_done), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 7)  chk("e7_nreset", 32'(nreset_o), 32'b0000);
            if (k == 8)  chk("e8_nreset", 32'(nreset_o), 32'b0001);
            if (k == 12) chk("e12_nreset", 32'(nreset_o), 32'b0011);
            if (k == 16) chk("e16_nreset", 32'(nreset_o), 32'b0111);
            if (k == 19) chk("e19_ready", 32'(ready), 32'd0);
            if (k == 20) begin
                chk("e20_nreset", 32'(nreset_o), 32'b1111);
                chk("e20_ready", 32'(ready), 32'd1);
                chk("e20_busy", 32'(busy), 32'd0);
            end
        end
        cycle();

        // Single-domain clear of domain 2; a second request at T+3 is dropped.
        dom_req = 1'b1; dom_sel = 2'd2;
        cycle();
        dom_req = 1'b0;
        chk("dom_t_nreset", 32'(nreset_o), 32'b1011);
        chk("dom_t_ready", 32'(ready), 32'd1);
        chk("dom_t_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) begin dom_req = 1'b1; dom_sel = 2'd0; end
            cycle();
            dom_req = 1'b0;
        end
        chk("dom_t7_nreset", 32'(nreset_o), 32'b1011);
        chk("dom_t7_done", 32'(dom_done), 32'd0);
        cycle();
        chk("dom_t8_nreset", 32'(nreset_o), 32'b1111);
        chk("dom_t8_done", 32'(dom_done), 32'd1);
        chk("dom_t8_busy", 32'(busy), 32'd0);
        cycle();
        chk("dom_t9_done", 32'(dom_done), 32'd0);

        // Global and domain request on the same edge: global wins.
        rst_req = 1'b1; dom_req = 1'b1; dom_sel = 2'd1;
        cycle();
        rst_req = 1'b0; dom_req = 1'b0;
        chk("both_nreset", 32'(nreset_o), 32'b0000);
        chk("both_ready", 32'(ready), 32'd0);
        chk("both_busy", 32'(busy), 32'd1);

        // Global request mid-release at relative edge 14, then full restart.
        for (int k = 1; k <= 13; k++) cycle();
        chk("pre_req_nreset", 32'(nreset_o), 32'b0011);
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        chk("req14_nreset", 32'(nreset_o), 32'b0000);
        chk("req14_ready", 32'(ready), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 19) chk("restart19_nreset", 32'(nreset_o), 32'b0111);
            if (k == 20) chk("restart20_ready", 32'(ready), 32'd1);
        end

        // Block reset during a domain clear.
        dom_req = 1'b1; dom_sel = 2'd1;
        cycle();
        dom_req = 1'b0;
        chk("dom1_nreset", 32'(nreset_o), 32'b1101);
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("dom_rst_nreset", 32'(nreset_o), 32'h0);
        chk("dom_rst_busy", 32'(busy), 32'd1);
        chk("dom_rst_ready", 32'(ready), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 8)  chk("after_rst8", 32'(nreset_o), 32'b0001);
            if (k == 20) chk("after_rst20", 32'(nreset_o), 32'b1111);
        end

        // A held global request keeps everything cleared.
        rst_req = 1'b1;
        repeat (30) cycle();
        chk("held_req_nreset", 32'(nreset_o), 32'h0);
        rst_req = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            reset   = ($urandom_range(0, 599) == 0);
            rst_req = ($urandom_range(0, 99) < 2);
            dom_req = ($urandom_range(0, 9) == 0);
            dom_sel = 2'($urandom_range(0, 3));
            cycle();
        end
        reset = 1'b0; rst_req = 1'b0; dom_req = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
